sdrd_rgb_packer: RTL and testbench

Sits between the SD SPI controller's raw byte stream and the pixel sink. It strips a fixed-length image-file header and packs payload bytes into OUT_W-wide words. Words are buffered in a DEPTH-entry FIFO and presented on a valid/ready interface. This replaces the fixed 64-bit, no-backpressure WR/DATA path with a configurable width, a configurable byte order, flow control (HOLD) and end-of-file handling.

---
 rtl/sdrd_rgb_packer.sv | 215 +++++++++++++++++++++
 tb/tb_sdrd_rgb_packer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrd_rgb_packer.sv
// rtl/sdrd_rgb_packer.sv - strips the image-file header and packs payload bytes into FIFO-buffered words
module sdrd_rgb_packer #(
  parameter int OUT_W       = 64,
  parameter int DEPTH       = 16,
  parameter int HDR_SKIP    = 54,
  parameter int LITTLE      = 1,
  parameter int HOLD_MARGIN = 4
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             START,
  input  logic [31:0]      FILE_SIZE,
  input  logic             BYTE_VALID,
  input  logic [7:0]       BYTE_DATA,
  output logic             OUT_VALID,
  output logic [OUT_W-1:0] OUT_DATA,
  input  logic             OUT_READY,
  output logic             HOLD,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVERFLOW
);

  localparam int NB = OUT_W / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(NB - 1);
  localparam logic [31:0]   SKIP32    = 32'(HDR_SKIP);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_C  = CW'(HOLD_MARGIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_PACK,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state;
  logic [31:0]      fsz;
  logic [31:0]      bcnt;
  logic [31:0]      bcnt_inc;
  logic [LW-1:0]    lane;
  logic [OUT_W-1:0] wbuf;
  logic [OUT_W-1:0] word_ins;
  int               pos;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic [OUT_W-1:0] push_data;

  logic             hold_r;
  logic             busy_r;
  logic             done_r;
  logic             ovf_r;

  assign bcnt_inc = bcnt + 32'd1;

  // Partial word with the incoming byte dropped into its lane
  always_comb begin
    pos      = (LITTLE != 0) ? int'(lane) : (NB - 1 - int'(lane));
    word_ins = wbuf;
    word_ins[pos*8 +: 8] = BYTE_DATA;
  end

  // A word is offered to the FIFO when the last lane fills or on the flush cycle
  always_comb begin
    push_req  = 1'b0;
    push_data = word_ins;
    if (!START) begin
      case (state)
        S_PACK: begin
          if (BYTE_VALID && (lane == LANE_LAST)) begin
            push_req = 1'b1;
          end
        end
        S_FLUSH: begin
          push_req  = 1'b1;
          push_data = wbuf;
        end
        default: ;
      endcase
    end
  end

  assign pop        = (count != '0) && OUT_READY;
  assign push_ok    = push_req && ((count != DEPTH_C) || pop);
  assign count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

  // FIFO storage; unused entries are never read so no reset is needed
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wptr] <= push_data;
    end
  end

  // FIFO pointers, occupancy, pause request and sticky drop flag
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      hold_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      count  <= count_next;
      hold_r <= ((DEPTH_C - count_next) <= MARGIN_C);
      if (START) begin
        ovf_r <= 1'b0;
      end else if (push_req && !push_ok) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // File sequencing: header skip, byte packing, final zero-padded flush
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state  <= S_IDLE;
      fsz    <= '0;
      bcnt   <= '0;
      lane   <= '0;
      wbuf   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (START) begin
      // Restart from any state; words already queued stay in the FIFO
      fsz  <= FILE_SIZE;
      bcnt <= '0;
      lane <= '0;
      wbuf <= '0;
      if (FILE_SIZE == 32'd0) begin
        state  <= S_DONE;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else if (HDR_SKIP == 0) begin
        state  <= S_PACK;
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end else begin
        state  <= S_SKIP;
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      case (state)
        S_SKIP: begin
          if (BYTE_VALID) begin
            bcnt <= bcnt_inc;
            // A file no longer than the header ends without any payload
            if ((fsz <= SKIP32) && (bcnt_inc == fsz)) begin
              state  <= S_DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else if (bcnt_inc == SKIP32) begin
              state <= S_PACK;
            end
          end
        end
        S_PACK: begin
          if (BYTE_VALID) begin
            bcnt <= bcnt_inc;
            if (lane == LANE_LAST) begin
              lane <= '0;
              wbuf <= '0;
            end else begin
              lane <= lane + LW'(1);
              wbuf <= word_ins;
            end
            if (bcnt_inc == fsz) begin
              if (lane == LANE_LAST) begin
                state  <= S_DONE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
              end else begin
                state <= S_FLUSH;
              end
            end
          end
        end
        S_FLUSH: begin
          // Unfilled lanes are already zero because wbuf clears on every push
          state  <= S_DONE;
          lane   <= '0;
          wbuf   <= '0;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign OUT_VALID = (count != '0);
  assign OUT_DATA  = OUT_VALID ? mem[rptr] : '0;
  assign HOLD      = hold_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign OVERFLOW  = ovf_r;

endmodule

// File: tb/tb_sdrd_rgb_packer.sv
// tb/tb_sdrd_rgb_packer.sv - self-checking bench for sdrd_rgb_packer
module tb_sdrd_rgb_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] fsize;
  logic        bv;
  logic [7:0]  bd;
  logic        ready_a_man;
  logic        rnd_mode;
  logic        rnd_bit = 1'b1;
  logic        ready_a;
  logic        ready_b;

  logic        va, vb, hold_a, hold_b, busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [63:0] da;
  logic [31:0] db;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] qa[$];
  logic [31:0] qb[$];
  logic [7:0]  rb[$];

  typedef struct {
    int          fsz;
    int          nw_a;
    logic [63:0] w0;
    logic [63:0] w1;
    bit          done_now;
    int          nw_b;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  assign ready_a = rnd_mode ? rnd_bit : ready_a_man;

  sdrd_rgb_packer #(
    .OUT_W(64), .DEPTH(16), .HDR_SKIP(54), .LITTLE(1), .HOLD_MARGIN(4)
  ) dut_a (
    .CLK(clk), .RST_X(rst_n), .START(start), .FILE_SIZE(fsize),
    .BYTE_VALID(bv), .BYTE_DATA(bd), .OUT_VALID(va), .OUT_DATA(da),
    .OUT_READY(ready_a), .HOLD(hold_a), .BUSY(busy_a), .DONE(done_a),
    .OVERFLOW(ovf_a)
  );

  sdrd_rgb_packer #(
    .OUT_W(32), .DEPTH(4), .HDR_SKIP(0), .LITTLE(0), .HOLD_MARGIN(1)
  ) dut_b (
    .CLK(clk), .RST_X(rst_n), .START(start), .FILE_SIZE(fsize),
    .BYTE_VALID(bv), .BYTE_DATA(bd), .OUT_VALID(vb), .OUT_DATA(db),
    .OUT_READY(ready_b), .HOLD(hold_b), .BUSY(busy_b), .DONE(done_b),
    .OVERFLOW(ovf_b)
  );

  // collect every word handed to the sink
  always @(negedge clk) begin
    if (va && ready_a) qa.push_back(da);
    if (vb && ready_b) qb.push_back(db);
  end

  // random backpressure for the wide instance
  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int fs);
    start = 1'b1;
    fsize = 32'(fs);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bv = 1'b1;
    bd = b;
    tick();
    bv = 1'b0;
  endtask

  task automatic drain();
    rnd_mode    = 1'b0;
    ready_a_man = 1'b1;
    ready_b     = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!va && !vb) break;
      tick();
    end
    chk("drain_empty", {va, vb}, 2'b00);
  endtask

  // reference: k-th word of a file is payload bytes placed by lane order, zero padded
  function automatic logic [255:0] exp_word(int skip, int nb, bit little, int k, int fs);
    logic [255:0] w = '0;
    for (int j = 0; j < nb; j++) begin
      int idx = skip + k * nb + j;
      int p   = little ? j : (nb - 1 - j);
      if (idx < fs) w[p*8 +: 8] = rb[idx];
    end
    return w;
  endfunction

  initial begin
    int base_a, base_b, fs, na, nb_exp, lim;

    tbl[0] = '{70, 2, 64'h3D3C3B3A39383736, 64'h4544434241403F3E, 1'b1, 18};
    tbl[1] = '{67, 2, 64'h3D3C3B3A39383736, 64'h0000004241403F3E, 1'b0, 17};
    tbl[2] = '{62, 1, 64'h3D3C3B3A39383736, 64'h0, 1'b1, 16};
    tbl[3] = '{55, 1, 64'h0000000000000036, 64'h0, 1'b0, 14};
    tbl[4] = '{54, 0, 64'h0, 64'h0, 1'b1, 14};
    tbl[5] = '{10, 0, 64'h0, 64'h0, 1'b1, 3};
    tbl[6] = '{0, 0, 64'h0, 64'h0, 1'b1, 0};

    rst_n = 1'b0; start = 1'b0; fsize = '0; bv = 1'b0; bd = '0;
    ready_a_man = 1'b1; ready_b = 1'b1; rnd_mode = 1'b0;
    repeat (3) tick();
    chk("reset_a", {va, da, hold_a, busy_a, done_a, ovf_a}, '0);
    chk("reset_b", {vb, db, hold_b, busy_b, done_b, ovf_b}, '0);
    rst_n = 1'b1;
    tick();

    // table of whole files on the wide instance, byte i of the file = i
    for (int i = 0; i < 7; i++) begin
      base_a = qa.size();
      base_b = qb.size();
      do_start(tbl[i].fsz);
      for (int j = 0; j < tbl[i].fsz; j++) send(8'(j));
      @(negedge clk);
      chk($sformatf("t%0d_done_now", i), done_a, tbl[i].done_now);
      chk($sformatf("t%0d_busy_now", i), busy_a, !tbl[i].done_now);
      tick();
      chk($sformatf("t%0d_done", i), done_a, 1'b1);
      drain();
      chk($sformatf("t%0d_nw_a", i), qa.size() - base_a, tbl[i].nw_a);
      if (tbl[i].nw_a > 0 && qa.size() > base_a) chk($sformatf("t%0d_w0", i), qa[base_a], tbl[i].w0);
      if (tbl[i].nw_a > 1 && qa.size() > base_a + 1) chk($sformatf("t%0d_w1", i), qa[base_a+1], tbl[i].w1);
      chk($sformatf("t%0d_nw_b", i), qb.size() - base_b, tbl[i].nw_b);
      chk($sformatf("t%0d_flags", i), {ovf_a, ovf_b, done_b, busy_a}, 4'b0010);
    end

    // big-endian lane order on the narrow instance
    do_start(4);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    @(negedge clk);
    chk("be_valid", vb, 1'b1);
    chk("be_data", db, 32'h11223344);
    chk("be_done", done_b, 1'b1);
    tick();
    drain();

    // fill a 4-deep FIFO with no sink: HOLD, overflow, then ordered drain
    ready_b = 1'b0;
    base_b  = qb.size();
    do_start(24);
    for (int j = 0; j < 24; j++) begin
      send(8'(j));
      if ((j + 1) % 4 == 0) begin
        @(negedge clk);
        chk($sformatf("ov_hold_w%0d", (j + 1) / 4), hold_b, ((j + 1) / 4) >= 3);
        chk($sformatf("ov_ovf_w%0d", (j + 1) / 4), ovf_b, ((j + 1) / 4) >= 5);
      end
    end
    chk("ov_done", done_b, 1'b1);
    chk("ov_head_stable", db, 32'h00010203);
    drain();
    chk("ov_count", qb.size() - base_b, 4);
    for (int k = 0; k < 4; k++) begin
      if (qb.size() > base_b + k)
        chk($sformatf("ov_word%0d", k), qb[base_b+k], {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
    end
    chk("ov_hold_after", hold_b, 1'b0);

    // full FIFO with a pop in the same cycle as the next push
    ready_b = 1'b0;
    base_b  = qb.size();
    do_start(20);
    for (int j = 0; j < 19; j++) send(8'(j));
    ready_b = 1'b1;
    send(8'd19);
    ready_b = 1'b0;
    @(negedge clk);
    chk("fp_ovf", ovf_b, 1'b0);
    chk("fp_valid", vb, 1'b1);
    chk("fp_head", db, 32'h04050607);
    chk("fp_hold", hold_b, 1'b1);
    drain();
    chk("fp_count", qb.size() - base_b, 5);
    for (int k = 0; k < 5; k++) begin
      if (qb.size() > base_b + k)
        chk($sformatf("fp_word%0d", k), qb[base_b+k], {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
    end

    // asynchronous reset in the middle of packing, then a header-only file
    ready_a_man = 1'b0;
    ready_b     = 1'b1;
    do_start(70);
    for (int j = 0; j < 64; j++) send(8'(j));
    @(negedge clk);
    chk("mr_pre_valid", {va, busy_a}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("mr_reset_a", {va, da, hold_a, busy_a, done_a, ovf_a}, '0);
    chk("mr_reset_b", {vb, db, hold_b, busy_b, done_b, ovf_b}, '0);
    tick();
    rst_n       = 1'b1;
    ready_a_man = 1'b1;
    tick();
    base_a = qa.size();
    do_start(10);
    for (int j = 0; j < 10; j++) send(8'(j));
    @(negedge clk);
    chk("mr_done", {done_a, busy_a}, 2'b10);
    tick();
    drain();
    chk("mr_no_words", qa.size() - base_a, 0);

    // randomized files against the reference model
    for (int t = 0; t < 8; t++) begin
      fs = $urandom_range(0, 160);
      rb.delete();
      for (int j = 0; j < fs; j++) rb.push_back(8'($urandom_range(0, 255)));
      base_a   = qa.size();
      base_b   = qb.size();
      ready_b  = 1'b1;
      rnd_mode = 1'b1;
      do_start(fs);
      for (int j = 0; j < fs; j++) begin
        send(rb[j]);
        repeat ($urandom_range(0, 2)) tick();
      end
      tick();
      drain();
      na     = (fs > 54) ? (fs - 54 + 7) / 8 : 0;
      nb_exp = (fs + 3) / 4;
      chk($sformatf("r%0d_nw_a", t), qa.size() - base_a, na);
      chk($sformatf("r%0d_nw_b", t), qb.size() - base_b, nb_exp);
      lim = (qa.size() - base_a < na) ? qa.size() - base_a : na;
      for (int k = 0; k < lim; k++)
        chk($sformatf("r%0d_a%0d", t, k), qa[base_a+k], exp_word(54, 8, 1'b1, k, fs));
      lim = (qb.size() - base_b < nb_exp) ? qb.size() - base_b : nb_exp;
      for (int k = 0; k < lim; k++)
        chk($sformatf("r%0d_b%0d", t, k), qb[base_b+k], exp_word(0, 4, 1'b0, k, fs));
      chk($sformatf("r%0d_flags", t), {done_a, done_b, ovf_a, ovf_b}, 4'b1100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
